// File: rtl/ecies_pkg.sv
// Shared widths, prefix constant, loader state encoding and derived-size helpers for the
// ECIES ciphertext front-end.
package ecies_pkg;

  localparam int unsigned DefMessageWidth = 32;
  localparam int unsigned DefIntegerSize  = 64;
  localparam int unsigned DefHashedWidth  = 512;

  localparam logic [7:0] SEC1_UNCOMPRESSED = 8'h04;

  // Beat counter saturates here; any frame this long is already a length error.
  localparam int unsigned CNT_W   = 7;
  localparam int unsigned CNT_MAX = 127;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLaunch,
    StRun,
    StRelease,
    StReport
  } state_e;

  function automatic int unsigned cipher_w(input int unsigned msg_w, input int unsigned int_w,
                                           input int unsigned hash_w);
    return msg_w + 2 * int_w + hash_w;
  endfunction

  function automatic int unsigned nbytes(input int unsigned msg_w, input int unsigned int_w,
                                         input int unsigned hash_w);
    return cipher_w(msg_w, int_w, hash_w) / 8 + 1;
  endfunction

endpackage

// File: rtl/ecies_cipher_loader_if.sv
// Byte stream, decryptor go/done and result handshakes of the ECIES cipher loader.
interface ecies_cipher_loader_if #(
  parameter int unsigned message_width = 32,
  parameter int unsigned integer_size  = 64,
  parameter int unsigned hashed_width  = 512
);
  localparam int unsigned CIPHER_W = message_width + 2 * integer_size + hashed_width;

  logic [7:0]               s_data;
  logic                     s_valid;
  logic                     s_last;
  logic                     s_ready;
  logic [CIPHER_W-1:0]      full_cipher;
  logic                     dec_go;
  logic                     dec_done;
  logic                     dec_valid;
  logic [message_width-1:0] dec_message;
  logic                     r_valid;
  logic                     r_ready;
  logic                     r_ok;
  logic                     r_err_fmt;
  logic [message_width-1:0] r_message;

  modport slave (
    input  s_data, s_valid, s_last, dec_done, dec_valid, dec_message, r_ready,
    output s_ready, full_cipher, dec_go, r_valid, r_ok, r_err_fmt, r_message
  );

  modport master (
    output s_data, s_valid, s_last, dec_done, dec_valid, dec_message, r_ready,
    input  s_ready, full_cipher, dec_go, r_valid, r_ok, r_err_fmt, r_message
  );

endinterface

// File: rtl/ecies_byte_shifter.sv
// MSB-first byte shift register that skips the prefix beat, with a saturating beat counter
// and a sticky flag for beats past the expected frame length.
module ecies_byte_shifter
  import ecies_pkg::*;
#(
  parameter int unsigned CIPHER_W = 672,
  parameter int unsigned NBYTES   = 85
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                beat_i,
  input  logic [7:0]          data_i,
  output logic [CIPHER_W-1:0] cipher_o,
  output logic [CNT_W-1:0]    count_o,
  output logic                overflow_o
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(CNT_MAX);

  logic [CIPHER_W-1:0] cipher_q, cipher_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;

  always_comb begin
    cipher_d = cipher_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clear_i) begin
      cipher_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (beat_i) begin
      // Beat 0 is the point-format prefix and never enters the cipher vector.
      if (count_q != '0 && count_q <= LastIdx) begin
        cipher_d = {cipher_q[CIPHER_W-9:0], data_i};
      end else if (count_q > LastIdx) begin
        ovf_d = 1'b1;
      end
      if (count_q != CntMax) begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cipher_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      cipher_q <= cipher_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign cipher_o   = cipher_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/ecies_cipher_loader.sv
// Front-end for the ECIES decryptor: validates and assembles a serialized ciphertext,
// runs the decryptor go/done handshake and reports the outcome on a result handshake.
module ecies_cipher_loader
  import ecies_pkg::*;
#(
  parameter int unsigned message_width = DefMessageWidth,
  parameter int unsigned integer_size  = DefIntegerSize,
  parameter int unsigned hashed_width  = DefHashedWidth
) (
  input logic                   clk,
  input logic                   rst,
  ecies_cipher_loader_if.slave  bus
);

  localparam int unsigned CIPHER_W = cipher_w(message_width, integer_size, hashed_width);
  localparam int unsigned NBYTES   = nbytes(message_width, integer_size, hashed_width);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(NBYTES - 1);

  state_e state_q, state_d;
  logic   dec_go_q, dec_go_d;
  logic   pfx_err_q, pfx_err_d;
  logic   ok_q, ok_d;
  logic   err_fmt_q, err_fmt_d;
  logic [message_width-1:0] msg_q, msg_d;

  logic                shift_clear;
  logic                beat;
  logic [CNT_W-1:0]    count;
  logic                overflow;
  logic [CIPHER_W-1:0] cipher;

  assign beat = bus.s_valid && (state_q == StLoad);

  ecies_byte_shifter #(
    .CIPHER_W (CIPHER_W),
    .NBYTES   (NBYTES)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (shift_clear),
    .beat_i     (beat),
    .data_i     (bus.s_data),
    .cipher_o   (cipher),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always_comb begin
    state_d     = state_q;
    dec_go_d    = dec_go_q;
    pfx_err_d   = pfx_err_q;
    ok_d        = ok_q;
    err_fmt_d   = err_fmt_q;
    msg_d       = msg_q;
    shift_clear = 1'b0;
    unique case (state_q)
      StIdle: begin
        shift_clear = 1'b1;
        pfx_err_d   = 1'b0;
        ok_d        = 1'b0;
        err_fmt_d   = 1'b0;
        msg_d       = '0;
        state_d     = StLoad;
      end
      StLoad: begin
        if (beat) begin
          if (count == '0 && bus.s_data != SEC1_UNCOMPRESSED) begin
            pfx_err_d = 1'b1;
          end
          // Errors raised on this very beat always also show up as a count mismatch.
          if (bus.s_last) begin
            if (pfx_err_q || overflow || count != LastIdx) begin
              ok_d      = 1'b0;
              err_fmt_d = 1'b1;
              msg_d     = '0;
              state_d   = StReport;
            end else begin
              state_d = StLaunch;
            end
          end
        end
      end
      StLaunch: begin
        dec_go_d = 1'b1;
        state_d  = StRun;
      end
      StRun: begin
        if (bus.dec_done) begin
          ok_d      = bus.dec_valid;
          err_fmt_d = 1'b0;
          msg_d     = bus.dec_valid ? bus.dec_message : '0;
          dec_go_d  = 1'b0;
          state_d   = StRelease;
        end
      end
      StRelease: begin
        if (!bus.dec_done) begin
          state_d = StReport;
        end
      end
      StReport: begin
        if (bus.r_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      dec_go_q  <= 1'b0;
      pfx_err_q <= 1'b0;
      ok_q      <= 1'b0;
      err_fmt_q <= 1'b0;
      msg_q     <= '0;
    end else begin
      state_q   <= state_d;
      dec_go_q  <= dec_go_d;
      pfx_err_q <= pfx_err_d;
      ok_q      <= ok_d;
      err_fmt_q <= err_fmt_d;
      msg_q     <= msg_d;
    end
  end

  assign bus.s_ready     = (state_q == StLoad);
  assign bus.r_valid     = (state_q == StReport);
  assign bus.dec_go      = dec_go_q;
  assign bus.full_cipher = cipher;
  assign bus.r_ok        = ok_q;
  assign bus.r_err_fmt   = err_fmt_q;
  assign bus.r_message   = msg_q;

endmodule

// File: tb/tb_ecies_cipher_loader.sv
// Self-checking bench for ecies_cipher_loader with a frame-level reference model.
module tb_ecies_cipher_loader;

  localparam int unsigned CW = 672;
  localparam int unsigned NB = 85;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ecies_cipher_loader_if #(
    .message_width (32),
    .integer_size  (64),
    .hashed_width  (512)
  ) bus ();

  ecies_cipher_loader #(
    .message_width (32),
    .integer_size  (64),
    .hashed_width  (512)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int go_cnt = 0;
  logic go_prev = 1'b0;
  logic [7:0]    frame[$];
  logic [CW-1:0] exp_flat;

  always @(negedge clk) begin
    if (bus.dec_go && !go_prev) go_cnt++;
    go_prev = bus.dec_go;
  end

  // Reference frame: prefix, then {Rx, Ry, msg, tag} MSB first, truncated or padded to len.
  task automatic build_frame(input logic [63:0] rx, input logic [63:0] ry,
                             input logic [31:0] m, input logic [511:0] tag,
                             input logic [7:0] pfx, input int len);
    exp_flat = {rx, ry, m, tag};
    frame.delete();
    frame.push_back(pfx);
    for (int i = 0; i < int'(NB) - 1; i++)
      if (frame.size() < len) frame.push_back(exp_flat[CW-1-8*i -: 8]);
    while (frame.size() < len) frame.push_back(8'($urandom));
  endtask

  task automatic send_frame(input bit gaps, output int acc, output bit tout);
    int  cyc;
    bit  rdy;
    bit  took;
    acc  = 0;
    tout = 0;
    cyc  = 0;
    for (int i = 0; i < frame.size(); i++) begin
      if (gaps && i > 0) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_data  = frame[i];
      bus.s_valid = 1'b1;
      bus.s_last  = (i == frame.size() - 1);
      took = 0;
      while (!took) begin
        rdy = bus.s_ready;
        @(posedge clk); #1;
        if (rdy) begin
          took = 1;
          acc++;
        end else if (++cyc > 300) begin
          tout = 1;
          bus.s_valid = 1'b0;
          bus.s_last  = 1'b0;
          return;
        end
      end
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // Decryptor model: waits for go, pulses done, keeps done high hold extra cycles.
  task automatic dec_respond(input bit v, input logic [31:0] m, input int hold,
                             output bit tout, output int early);
    int cyc = 0;
    tout  = 0;
    early = 0;
    while (!bus.dec_go) begin
      @(posedge clk); #1;
      if (++cyc > 50) begin
        tout = 1;
        return;
      end
    end
    bus.dec_done    = 1'b1;
    bus.dec_valid   = v;
    bus.dec_message = m;
    @(posedge clk); #1;
    for (int k = 0; k < hold; k++) begin
      if (bus.r_valid) early++;
      @(posedge clk); #1;
    end
    if (bus.r_valid) early++;
    bus.dec_done    = 1'b0;
    bus.dec_valid   = 1'b0;
    bus.dec_message = $urandom;
  endtask

  task automatic get_result(output logic ok, output logic ef, output logic [31:0] msg,
                            output bit tout);
    int cyc = 0;
    tout = 0;
    ok   = 1'bx;
    ef   = 1'bx;
    msg  = 'x;
    while (!bus.r_valid) begin
      @(posedge clk); #1;
      if (++cyc > 300) begin
        tout = 1;
        return;
      end
    end
    ok  = bus.r_ok;
    ef  = bus.r_err_fmt;
    msg = bus.r_message;
    bus.r_ready = 1'b1;
    @(posedge clk); #1;
    bus.r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready got %b want 0", bus.s_ready); end
    checks++; if (bus.dec_go !== 1'b0) begin errors++; $display("FAIL reset_dec_go got %b want 0", bus.dec_go); end
    checks++; if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL reset_r_valid got %b want 0", bus.r_valid); end
    checks++; if (bus.r_ok !== 1'b0) begin errors++; $display("FAIL reset_r_ok got %b want 0", bus.r_ok); end
    checks++; if (bus.r_err_fmt !== 1'b0) begin errors++; $display("FAIL reset_r_err_fmt got %b want 0", bus.r_err_fmt); end
    checks++; if (bus.r_message !== 32'h0) begin errors++; $display("FAIL reset_r_message got %h want 0", bus.r_message); end
    checks++; if (bus.full_cipher !== '0) begin errors++; $display("FAIL reset_full_cipher got %h want 0", bus.full_cipher); end
    rst = 1'b0;
  endtask

  task automatic test_good_frame();
    int acc, early;
    bit tout;
    logic ok, ef;
    logic [31:0] msg;
    build_frame(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 32'hDEADBEEF, {64{8'h5A}},
                8'h04, NB);
    send_frame(0, acc, tout);
    checks++; if (tout || acc != int'(NB)) begin errors++; $display("FAIL good_accept got %0d want %0d (timeout %0d)", acc, NB, tout); end
    checks++; if (bus.dec_go !== 1'b0) begin errors++; $display("FAIL good_go_early got %b want 0", bus.dec_go); end
    checks++; if (bus.s_ready !== 1'b0) begin errors++; $display("FAIL good_s_ready_after_last got %b want 0", bus.s_ready); end
    @(posedge clk); #1;
    checks++; if (bus.dec_go !== 1'b1) begin errors++; $display("FAIL good_go_latency got %b want 1", bus.dec_go); end
    checks++; if (bus.full_cipher !== exp_flat) begin errors++; $display("FAIL good_cipher got %h want %h", bus.full_cipher, exp_flat); end
    dec_respond(1, 32'hCAFEF00D, 0, tout, early);
    checks++; if (tout) begin errors++; $display("FAIL good_dec_go_wait got timeout want go"); end
    checks++; if (bus.dec_go !== 1'b0 || bus.r_valid !== 1'b0) begin errors++; $display("FAIL good_release got go=%b rv=%b want 0 0", bus.dec_go, bus.r_valid); end
    checks++; if (bus.full_cipher !== exp_flat) begin errors++; $display("FAIL good_cipher_stable got %h want %h", bus.full_cipher, exp_flat); end
    @(posedge clk); #1;
    checks++; if (bus.r_valid !== 1'b1) begin errors++; $display("FAIL good_rvalid_latency got %b want 1", bus.r_valid); end
    get_result(ok, ef, msg, tout);
    checks++; if (tout || ok !== 1'b1 || ef !== 1'b0 || msg !== 32'hCAFEF00D) begin errors++; $display("FAIL good_result got ok=%b fmt=%b msg=%h want 1 0 cafef00d", ok, ef, msg); end
    checks++; if (bus.r_valid !== 1'b0) begin errors++; $display("FAIL good_rvalid_drop got %b want 0", bus.r_valid); end
  endtask

  // Frames the model says are malformed: all beats accepted, no go, fmt error reported.
  task automatic test_format_errors();
    int acc, g0;
    bit tout;
    logic ok, ef;
    logic [31:0] msg;
    logic [7:0]  pfx_tab[3] = '{8'h02, 8'h04, 8'h04};
    int          len_tab[3] = '{85, 84, 90};
    for (int t = 0; t < 3; t++) begin
      build_frame({$urandom, $urandom}, {$urandom, $urandom}, $urandom, {16{$urandom}},
                  pfx_tab[t], len_tab[t]);
      g0 = go_cnt;
      send_frame(0, acc, tout);
      checks++; if (tout || acc != len_tab[t]) begin errors++; $display("FAIL fmt%0d_accept got %0d want %0d", t, acc, len_tab[t]); end
      get_result(ok, ef, msg, tout);
      checks++; if (tout || ok !== 1'b0 || ef !== 1'b1 || msg !== 32'h0) begin errors++; $display("FAIL fmt%0d_result got ok=%b fmt=%b msg=%h want 0 1 0", t, ok, ef, msg); end
      checks++; if (go_cnt != g0) begin errors++; $display("FAIL fmt%0d_no_go got %0d gos want 0", t, go_cnt - g0); end
    end
  endtask

  task automatic test_mac_fail_and_hold();
    int acc, early;
    bit tout;
    logic ok, ef;
    logic [31:0] msg;
    build_frame({$urandom, $urandom}, {$urandom, $urandom}, $urandom, {16{$urandom}}, 8'h04, NB);
    send_frame(0, acc, tout);
    dec_respond(0, $urandom | 32'h1, 0, tout, early);
    get_result(ok, ef, msg, tout);
    checks++; if (tout || ok !== 1'b0 || ef !== 1'b0 || msg !== 32'h0) begin errors++; $display("FAIL mac_fail got ok=%b fmt=%b msg=%h want 0 0 0", ok, ef, msg); end
    build_frame({$urandom, $urandom}, {$urandom, $urandom}, $urandom, {16{$urandom}}, 8'h04, NB);
    send_frame(0, acc, tout);
    dec_respond(1, 32'h13572468, 5, tout, early);
    checks++; if (tout || early != 0) begin errors++; $display("FAIL done_hold_early got %0d early r_valid cycles want 0", early); end
    get_result(ok, ef, msg, tout);
    checks++; if (tout || ok !== 1'b1 || msg !== 32'h13572468) begin errors++; $display("FAIL done_hold_result got ok=%b msg=%h want 1 13572468", ok, msg); end
  endtask

  task automatic test_gaps_and_rready_hold();
    int acc, early, cyc, bad;
    bit tout;
    logic ok, ef;
    logic [31:0] msg;
    build_frame(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 32'hDEADBEEF, {64{8'h5A}},
                8'h04, NB);
    send_frame(1, acc, tout);
    checks++; if (tout || acc != int'(NB)) begin errors++; $display("FAIL gaps_accept got %0d want %0d", acc, NB); end
    @(posedge clk); #1;
    checks++; if (bus.full_cipher !== exp_flat) begin errors++; $display("FAIL gaps_cipher got %h want %h", bus.full_cipher, exp_flat); end
    dec_respond(1, 32'h0BADF00D, 0, tout, early);
    cyc = 0;
    while (!bus.r_valid && cyc < 50) begin @(posedge clk); #1; cyc++; end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.r_valid !== 1'b1 || bus.r_ok !== 1'b1 || bus.r_err_fmt !== 1'b0 ||
          bus.r_message !== 32'h0BADF00D) bad++;
      @(posedge clk); #1;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rready_hold_stable got %0d unstable cycles want 0", bad); end
    get_result(ok, ef, msg, tout);
    checks++; if (tout || ok !== 1'b1 || msg !== 32'h0BADF00D) begin errors++; $display("FAIL rready_hold_result got ok=%b msg=%h want 1 0badf00d", ok, msg); end
  endtask

  task automatic test_mid_run_reset();
    int acc, early, cyc;
    bit tout;
    logic ok, ef;
    logic [31:0] msg;
    build_frame({$urandom, $urandom}, {$urandom, $urandom}, $urandom, {16{$urandom}}, 8'h04, NB);
    send_frame(0, acc, tout);
    cyc = 0;
    while (!bus.dec_go && cyc < 20) begin @(posedge clk); #1; cyc++; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.dec_go !== 1'b0 || bus.r_valid !== 1'b0) begin errors++; $display("FAIL midrst_outputs got go=%b rv=%b want 0 0", bus.dec_go, bus.r_valid); end
    checks++; if (bus.full_cipher !== '0) begin errors++; $display("FAIL midrst_cipher got %h want 0", bus.full_cipher); end
    rst = 1'b0;
    build_frame(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 32'hDEADBEEF, {64{8'h5A}},
                8'h04, NB);
    send_frame(0, acc, tout);
    dec_respond(1, 32'hCAFEF00D, 1, tout, early);
    get_result(ok, ef, msg, tout);
    checks++; if (tout || ok !== 1'b1 || ef !== 1'b0 || msg !== 32'hCAFEF00D) begin errors++; $display("FAIL midrst_recover got ok=%b fmt=%b msg=%h want 1 0 cafef00d", ok, ef, msg); end
  endtask

  task automatic test_random();
    int acc, early, g0, len, kind;
    bit tout, gaps, dv, exp_fmt, exp_ok;
    logic ok, ef;
    logic [31:0] msg, dm, exp_msg;
    logic [7:0]  pfx;
    for (int it = 0; it < 10; it++) begin
      kind = $urandom_range(0, 4);
      pfx  = 8'h04;
      if (kind == 1) begin
        pfx = 8'($urandom);
        if (pfx == 8'h04) pfx = 8'h05;
      end
      len  = (kind == 2) ? $urandom_range(1, 84) : (kind == 3) ? $urandom_range(86, 140) : NB;
      dv   = (kind != 4);
      dm   = $urandom | 32'h1;
      gaps = 1'($urandom_range(0, 1));
      build_frame({$urandom, $urandom}, {$urandom, $urandom}, $urandom, {16{$urandom}}, pfx, len);
      exp_fmt = (frame.size() != NB) || (frame[0] != 8'h04);
      exp_ok  = !exp_fmt && dv;
      exp_msg = exp_ok ? dm : 32'h0;
      g0 = go_cnt;
      send_frame(gaps, acc, tout);
      checks++; if (tout || acc != len) begin errors++; $display("FAIL rnd%0d_accept got %0d want %0d", it, acc, len); end
      if (!exp_fmt) begin
        dec_respond(dv, dm, $urandom_range(0, 3), tout, early);
        checks++; if (tout || early != 0 || bus.full_cipher !== exp_flat) begin errors++; $display("FAIL rnd%0d_cipher got %h want %h", it, bus.full_cipher, exp_flat); end
      end
      get_result(ok, ef, msg, tout);
      checks++; if (tout || ok !== exp_ok || ef !== exp_fmt || msg !== exp_msg) begin errors++; $display("FAIL rnd%0d_result got ok=%b fmt=%b msg=%h want %b %b %h", it, ok, ef, msg, exp_ok, exp_fmt, exp_msg); end
      checks++; if (go_cnt - g0 != (exp_fmt ? 0 : 1)) begin errors++; $display("FAIL rnd%0d_go_count got %0d want %0d", it, go_cnt - g0, exp_fmt ? 0 : 1); end
    end
  endtask

  initial begin
    bus.s_data      = 8'h00;
    bus.s_valid     = 1'b0;
    bus.s_last      = 1'b0;
    bus.dec_done    = 1'b0;
    bus.dec_valid   = 1'b0;
    bus.dec_message = 32'h0;
    bus.r_ready     = 1'b0;
    test_reset();
    test_good_frame();
    test_format_errors();
    test_mac_fail_and_hold();
    test_gaps_and_rready_hold();
    test_mid_run_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
